instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: instruction buffer entries, power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-006 SHALL have port imem_addr, output, 32 bits: word-aligned read address, valid while imem_req=1.
REQ-007 SHALL have port imem_rdata, input, 32 bits: read data, valid in the cycle after an accepted request.
REQ-008 SHALL have port redirect, input, 1 bit: branch/jump redirect strobe from execute.
REQ-009 SHALL have port redirect_pc, input, 32 bits: redirect target, sampled when redirect=1.
REQ-010 SHALL have port dec_valid, output, 1 bit: instruction available to decode.
REQ-011 SHALL have port dec_instr, output, 32 bits: instruction word.
REQ-012 SHALL have port dec_pc, output, 32 bits: address of dec_instr.
REQ-013 SHALL have port dec_ready, input, 1 bit: decode accepts the instruction.

Function
REQ-014 SHALL hold a fetch PC register; imem always accepts, so each cycle with imem_req=1 is one accepted request, imem_addr = PC.
REQ-015 SHALL advance PC by 4 on every accepted request, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-016 SHALL track at most one in-flight request (inflight flag plus its PC); the response is written to the buffer at the next rising edge.
REQ-017 SHALL assert imem_req iff rst=0, redirect=0, and (count + inflight - pop) < FIFO_DEPTH, where pop = dec_valid & dec_ready.
REQ-018 SHALL sustain one instruction per cycle while dec_ready=1 continuously.
REQ-019 SHALL present the FIFO head on dec_instr/dec_pc, with dec_valid = (count != 0), in program order.
REQ-020 SHALL hold dec_instr and dec_pc stable while dec_valid=1 and dec_ready=0.
REQ-021 SHALL handle push and pop in the same cycle with count unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-022 On redirect=1: SHALL flush the buffer (count=0, dec_valid=0 next cycle), discard any in-flight response, load PC with {redirect_pc[31:2],2'b00}, and issue no request that cycle.
REQ-023 Redirect SHALL take priority over a simultaneous pop, response write, or request.
REQ-024 A redirect held for consecutive cycles SHALL use the last cycle's redirect_pc; fetch resumes in the first cycle after redirect deasserts.
REQ-025 Latency: a request accepted at edge N SHALL appear on dec_valid after edge N+1 if the buffer was empty.
REQ-026 After a redirect at edge R, the target SHALL be requested in the cycle after R and presented after edge R+2.
REQ-027 dec_ready while dec_valid=0 SHALL have no effect.

Reset
REQ-028 While rst=1 SHALL force PC=RESET_PC, count=0, inflight=0, pointers=0, imem_req=0, dec_valid=0, dec_instr=0, dec_pc=0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard the buffer and the in-flight response immediately.
REQ-030 In the first cycle with rst=0, SHALL drive imem_req=1 with imem_addr=RESET_PC.

Verification
REQ-031 SHALL verify reset release with imem returning addr+1 and dec_ready=1 -> dec_pc sequence 0,4,8,C, one per cycle, dec_valid first high two edges after release.
REQ-032 SHALL verify dec_ready held 0 for 5 cycles -> two entries buffered, imem_req=0 after the fill, dec_pc=0 stable; on release, 0 then 4 then 8 with no gaps or duplicates.
REQ-033 SHALL verify redirect to 32'h0000_0103 with one entry buffered and one in flight -> both dropped, next request address 32'h0000_0100, dec_pc=0x100 two edges later.
REQ-034 SHALL verify redirect to 32'hFFFF_FFFC -> dec_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
REQ-035 SHALL verify rst asserted asynchronously between edges while the buffer is full -> dec_valid and imem_req go 0 before the next edge, and fetch restarts at RESET_PC.
REQ-036 SHALL verify redirect and dec_ready=1 in the same cycle -> no instruction from the old path is delivered after that edge.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Sequential instruction fetch with a small decode buffer and
//             redirect/flush handling; one instruction per cycle sustained.
//  Revision : 1.0
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   c_depth   = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] c_ptr_one = PW'(1);

  logic [31:0]   r_pc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_instr [FIFO_DEPTH];
  logic [31:0]   r_mem_pc    [FIFO_DEPTH];

  logic          w_pop;
  logic          w_push;
  logic [CW:0]   w_occ;
  logic          w_unused_bits;

  assign w_unused_bits = ^redirect_pc[1:0];

  // Occupancy counts the in-flight slot so a response always has room.
  assign w_pop  = dec_valid & dec_ready;
  assign w_push = r_inflight & ~redirect;
  assign w_occ  = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);

  assign imem_req  = ~rst & ~redirect & (w_occ < c_depth);
  assign imem_addr = r_pc;

  assign dec_valid = (r_count != '0);
  assign dec_instr = dec_valid ? r_mem_instr[r_rd_ptr] : 32'h0;
  assign dec_pc    = dec_valid ? r_mem_pc[r_rd_ptr]    : 32'h0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else if (redirect) begin
      // Redirect wins over pop, response write and request alike.
      r_pc       <= {redirect_pc[31:2], 2'b00};
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      r_inflight    <= imem_req;
      r_inflight_pc <= r_pc;
      if (imem_req) begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Directed bench for instr_fetch; imem returns addr+1.
//  Revision : 1.0
// ============================================================================
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q [$];

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata <= imem_req ? imem_addr + 32'd1 : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Scoreboard: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && !redirect && dec_valid && dec_ready) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_extra: observed dec_pc %h expected no delivery", dec_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc", dec_pc, e);
        check("sb_instr", dec_instr, e + 32'd1);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    #2;
    check("rst_req",   {31'h0, imem_req},  32'h0);
    check("rst_valid", {31'h0, dec_valid}, 32'h0);
    check("rst_instr", dec_instr, 32'h0);
    check("rst_pc",    dec_pc,    32'h0);
    tick(); tick();

    // Reset release with continuous dec_ready
    rst = 1'b0; dec_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    settle();
    check("first_req",  {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
    tick(); settle();
    check("lat_valid0", {31'h0, dec_valid}, 32'h0);
    check("second_addr", imem_addr, 32'h4);
    tick(); settle();
    check("lat_valid1", {31'h0, dec_valid}, 32'h1);
    check("lat_pc", dec_pc, 32'h0);
    tick(); tick(); tick();
    tick(); dec_ready = 1'b0; settle();
    check("s1_drained", 32'(exp_q.size()), 32'h0);
    check("s1_head", dec_pc, 32'h10);
    tick(); settle();
    check("full_pc",  dec_pc, 32'h10);
    check("full_req", {31'h0, imem_req}, 32'h0);

    // Asynchronous reset between edges with a full buffer
    #1; rst = 1'b1; #1;
    check("arst_valid", {31'h0, dec_valid}, 32'h0);
    check("arst_req",   {31'h0, imem_req},  32'h0);
    check("arst_pc",    dec_pc, 32'h0);

    tick(); rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    settle();
    check("restart_req",  {31'h0, imem_req}, 32'h1);
    check("restart_addr", imem_addr, 32'h0);
    tick(); settle();
    check("stall_valid0", {31'h0, dec_valid}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick(); settle();
      check("stall_valid", {31'h0, dec_valid}, 32'h1);
      check("stall_pc",    dec_pc, 32'h0);
      check("stall_instr", dec_instr, 32'h1);
      check("stall_req",   {31'h0, imem_req}, 32'h0);
    end
    tick(); dec_ready = 1'b1; settle();
    tick(); tick();

    // Redirect with one entry buffered and one in flight
    tick(); dec_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103; settle();
    check("s2_drained", 32'(exp_q.size()), 32'h0);
    check("pre_redir_pc", dec_pc, 32'hC);
    check("redir_noreq", {31'h0, imem_req}, 32'h0);
    tick(); redirect = 1'b0; settle();
    check("redir_flush", {31'h0, dec_valid}, 32'h0);
    check("redir_req",   {31'h0, imem_req}, 32'h1);
    check("redir_addr",  imem_addr, 32'h0000_0100);
    tick(); settle();
    check("redir_lat0", {31'h0, dec_valid}, 32'h0);
    tick(); settle();
    check("redir_valid", {31'h0, dec_valid}, 32'h1);
    check("redir_pc",    dec_pc, 32'h0000_0100);
    check("redir_instr", dec_instr, 32'h0000_0101);

    // Redirect to the top of memory coinciding with dec_ready
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; dec_ready = 1'b1;
    #1;
    check("wrap_noreq", {31'h0, imem_req}, 32'h0);
    tick(); redirect = 1'b0; settle();
    check("wrap_flush", {31'h0, dec_valid}, 32'h0);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick(); settle();
    check("wrap_lat0",  {31'h0, dec_valid}, 32'h0);
    check("wrap_addr1", imem_addr, 32'h0);
    tick(); settle();
    check("wrap_valid", {31'h0, dec_valid}, 32'h1);
    tick(); tick();
    tick(); dec_ready = 1'b0; settle();
    check("s3_drained", 32'(exp_q.size()), 32'h0);
    check("s3_head", dec_pc, 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
